// File: rtl/uart_pkg.sv
// Shared UART constants and receiver FSM encodings.
// The Tx block pulls its baud timing from here as well.
package uart_pkg;

  localparam int CLK_FREQ     = 50_000_000;
  localparam int BAUD         = 115200;
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int DATA_BITS    = 8;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  typedef logic [DATA_BITS-1:0] byte_t;

endpackage

// File: rtl/uart_rx_if.sv
// Parallel-side bundle of the UART receiver.
// The receiver drives it; user logic consumes it.
interface uart_rx_if;
  import uart_pkg::*;

  byte_t o_rx_d;
  logic  o_rx_valid;
  logic  o_frame_err;
  logic  o_rx_busy;

  modport master (
    output o_rx_d,
    output o_rx_valid,
    output o_frame_err,
    output o_rx_busy
  );

  modport slave (
    input o_rx_d,
    input o_rx_valid,
    input o_frame_err,
    input o_rx_busy
  );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line.
// Presets to 1 so reset looks like an idle line.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling.
// Frame errors park in BREAK until the line idles.
module uart_rx
  import uart_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_rx_d,
  uart_rx_if.master rx_if
);

  localparam logic [CNT_W-1:0] CNT_HALF =
    CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL =
    CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_s;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  byte_t            shift;
  byte_t            rx_d;
  logic             rx_valid;
  logic             frame_err;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (i_rx_d),
    .q     (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_d      <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_FULL) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            // IDLE is re-entered mid-stop so the next start edge is not missed
            if (rx_s) begin
              rx_d     <= shift;
              rx_valid <= 1'b1;
              state    <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_if.o_rx_d      = rx_d;
  assign rx_if.o_rx_valid  = rx_valid;
  assign rx_if.o_frame_err = frame_err;
  assign rx_if.o_rx_busy   = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames for uart_rx,
// checked against a frame-level byte model.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int T = CLKS_PER_BIT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic i_rx_d = 1'b1;

  uart_rx_if rx_if ();

  uart_rx dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_rx_d (i_rx_d),
    .rx_if  (rx_if)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  byte_t got_q[$];
  int    ferr_cyc = 0;
  int    both_cyc = 0;
  int    unstable = 0;
  byte_t prev_d   = 8'h00;

  byte_t exp_q[$];
  int    exp_ferr  = 0;
  byte_t last_good = 8'h00;

  // observe the parallel side just after each edge
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      prev_d = 8'h00;
    end else begin
      if (rx_if.o_rx_valid) got_q.push_back(rx_if.o_rx_d);
      if (rx_if.o_frame_err) ferr_cyc++;
      if (rx_if.o_rx_valid && rx_if.o_frame_err) both_cyc++;
      if (!rx_if.o_rx_valid && rx_if.o_rx_d !== prev_d) unstable++;
      prev_d = rx_if.o_rx_d;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input byte_t b,
                            input logic stop,
                            input int per);
    i_rx_d = 1'b0;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i_rx_d = b[i];
      repeat (per) @(negedge clk);
    end
    i_rx_d = stop;
    repeat (per) @(negedge clk);
    if (stop) begin
      exp_q.push_back(b);
      last_good = b;
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic check_rx(input string tag);
    int n;
    n = exp_q.size();
    chk({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++)
      if (i < got_q.size())
        chk({tag, "_byte"}, got_q[i], exp_q[i]);
    chk({tag, "_ferr"}, ferr_cyc, exp_ferr);
    chk({tag, "_both"}, both_cyc, 0);
    chk({tag, "_stable"}, unstable, 0);
    chk({tag, "_rx_d"}, rx_if.o_rx_d, last_good);
  endtask

  initial begin
    int per;
    int gap;
    byte_t b;

    repeat (3) @(negedge clk);
    chk("rst_rx_d", rx_if.o_rx_d, 8'h00);
    chk("rst_valid", rx_if.o_rx_valid, 1'b0);
    chk("rst_ferr", rx_if.o_frame_err, 1'b0);
    chk("rst_busy", rx_if.o_rx_busy, 1'b0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    send_frame(8'h55, 1'b1, T);
    repeat (5) @(negedge clk);
    check_rx("single");

    send_frame(8'hA5, 1'b1, T);
    send_frame(8'h3C, 1'b1, T);
    send_frame(8'h00, 1'b1, T);
    send_frame(8'hFF, 1'b1, T);
    repeat (5) @(negedge clk);
    check_rx("b2b");

    i_rx_d = 1'b0;
    repeat (5) @(negedge clk);
    chk("glitch_busy", rx_if.o_rx_busy, 1'b1);
    repeat (95) @(negedge clk);
    i_rx_d = 1'b1;
    repeat (220) @(negedge clk);
    chk("glitch_idle", rx_if.o_rx_busy, 1'b0);
    check_rx("glitch");

    send_frame(8'hC3, 1'b0, T);
    repeat (20 * T) @(negedge clk);
    chk("break_busy", rx_if.o_rx_busy, 1'b1);
    check_rx("break");
    i_rx_d = 1'b1;
    repeat (T) @(negedge clk);
    chk("break_exit", rx_if.o_rx_busy, 1'b0);
    send_frame(8'h5A, 1'b1, T);
    repeat (5) @(negedge clk);
    check_rx("after_break");

    b = 8'h81;
    i_rx_d = 1'b0;
    repeat (T) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      i_rx_d = b[i];
      repeat (T) @(negedge clk);
    end
    chk("pre_rst_busy", rx_if.o_rx_busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    i_rx_d = 1'b1;
    last_good = 8'h00;
    chk("mid_rst_rx_d", rx_if.o_rx_d, 8'h00);
    chk("mid_rst_busy", rx_if.o_rx_busy, 1'b0);
    chk("mid_rst_valid", rx_if.o_rx_valid, 1'b0);
    repeat (2 * T) @(negedge clk);
    check_rx("mid_rst");
    send_frame(8'h81, 1'b1, T);
    repeat (5) @(negedge clk);
    check_rx("after_rst");

    send_frame(8'h96, 1'b1, 425);
    repeat (5) @(negedge clk);
    send_frame(8'h96, 1'b1, 443);
    repeat (5) @(negedge clk);
    check_rx("tol");

    for (int k = 0; k < 2; k++) begin
      b   = byte_t'($urandom);
      per = $urandom_range(425, 443);
      gap = $urandom_range(0, 40);
      send_frame(b, 1'b1, per);
      repeat (gap) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check_rx("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
